router_port_ctrl: RTL and testbench

Output-port controller for the 1x3 router. It latches the destination address decoded by the router FSM and steers the per-port FIFO write enables. It muxes the selected FIFO's full flag back to the FSM and drives per-port valid outputs. It also runs one timeout watchdog per output port, which issues a soft reset to a FIFO whose client has left data unread for too long. It sits between the router FSM and the three output FIFOs.

---
 rtl/router_port_ctrl_if.sv | 44 ++++
 rtl/router_port_ctrl.sv | 105 ++++++++++
 tb/tb_router_port_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/router_port_ctrl_if.sv
// Signal bundle between the router FSM / FIFOs / clients and the output-port controller.
// master drives the request side; slave is the controller itself.
interface router_port_ctrl_if;
    logic       detect_add;
    logic [1:0] data_in;
    logic       write_enb_reg;
    logic       empty_0;
    logic       empty_1;
    logic       empty_2;
    logic       full_0;
    logic       full_1;
    logic       full_2;
    logic       read_enb_0;
    logic       read_enb_1;
    logic       read_enb_2;
    logic [2:0] write_enb;
    logic       fifo_full;
    logic       vld_out_0;
    logic       vld_out_1;
    logic       vld_out_2;
    logic       soft_reset_0;
    logic       soft_reset_1;
    logic       soft_reset_2;

    modport master (
        output detect_add, data_in, write_enb_reg,
        output empty_0, empty_1, empty_2,
        output full_0, full_1, full_2,
        output read_enb_0, read_enb_1, read_enb_2,
        input  write_enb, fifo_full,
        input  vld_out_0, vld_out_1, vld_out_2,
        input  soft_reset_0, soft_reset_1, soft_reset_2
    );

    modport slave (
        input  detect_add, data_in, write_enb_reg,
        input  empty_0, empty_1, empty_2,
        input  full_0, full_1, full_2,
        input  read_enb_0, read_enb_1, read_enb_2,
        output write_enb, fifo_full,
        output vld_out_0, vld_out_1, vld_out_2,
        output soft_reset_0, soft_reset_1, soft_reset_2
    );
endinterface

// File: rtl/router_port_ctrl.sv
// Output-port controller for the 1x3 router: latches the destination address, steers FIFO
// write enables, returns the addressed full flag and runs a per-port unread-data watchdog.
module router_port_ctrl #(
    parameter int unsigned TIMEOUT = 30
) (
    input  logic                clk,
    input  logic                resetn,
    router_port_ctrl_if.slave   bus
);

    localparam int unsigned     CntW   = $clog2(TIMEOUT);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

    logic [1:0]      addr_q, addr_d;
    logic [2:0]      empty, full, rd, stall;
    logic [CntW-1:0] cnt_q [3];
    logic [CntW-1:0] cnt_d [3];
    logic [2:0]      sr_q, sr_d;
    logic [2:0]      write_enb;
    logic            fifo_full;

    assign empty = {bus.empty_2, bus.empty_1, bus.empty_0};
    assign full  = {bus.full_2, bus.full_1, bus.full_0};
    assign rd    = {bus.read_enb_2, bus.read_enb_1, bus.read_enb_0};
    assign stall = ~empty & ~rd;

    // 2'b11 is latched as-is and selects no port.
    always_comb begin
        addr_d = addr_q;
        if (bus.detect_add) begin
            addr_d = bus.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            addr_q <= 2'b11;
        end else begin
            addr_q <= addr_d;
        end
    end

    // Decodes the registered address only, so a same-cycle latch affects the next cycle.
    always_comb begin
        write_enb = 3'b000;
        fifo_full = 1'b0;
        case (addr_q)
            2'b00: begin
                write_enb = {2'b00, bus.write_enb_reg};
                fifo_full = full[0];
            end
            2'b01: begin
                write_enb = {1'b0, bus.write_enb_reg, 1'b0};
                fifo_full = full[1];
            end
            2'b10: begin
                write_enb = {bus.write_enb_reg, 2'b00};
                fifo_full = full[2];
            end
            default: begin
                write_enb = 3'b000;
                fifo_full = 1'b0;
            end
        endcase
    end

    // Count restarts from zero after each pulse so a persistent stall re-fires every TIMEOUT.
    always_comb begin
        sr_d = 3'b000;
        for (int n = 0; n < 3; n++) begin
            cnt_d[n] = '0;
            if (stall[n]) begin
                if (cnt_q[n] == CntMax) begin
                    sr_d[n] = 1'b1;
                end else begin
                    cnt_d[n] = cnt_q[n] + CntW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sr_q <= 3'b000;
            for (int n = 0; n < 3; n++) begin
                cnt_q[n] <= '0;
            end
        end else begin
            sr_q <= sr_d;
            for (int n = 0; n < 3; n++) begin
                cnt_q[n] <= cnt_d[n];
            end
        end
    end

    assign bus.write_enb    = write_enb;
    assign bus.fifo_full    = fifo_full;
    assign bus.vld_out_0    = ~empty[0];
    assign bus.vld_out_1    = ~empty[1];
    assign bus.vld_out_2    = ~empty[2];
    assign bus.soft_reset_0 = sr_q[0];
    assign bus.soft_reset_1 = sr_q[1];
    assign bus.soft_reset_2 = sr_q[2];

endmodule

// File: tb/tb_router_port_ctrl.sv
// Directed bench for router_port_ctrl: table-driven address steering plus watchdog sequences.
module tb_router_port_ctrl;

    logic clk;
    logic resetn;
    int   total;
    int   passed;

    router_port_ctrl_if bus ();

    router_port_ctrl #(
        .TIMEOUT (30)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       da;
        logic [1:0] din;
        logic       we;
        logic [2:0] full;
        logic [2:0] empty;
        logic [2:0] exp_we;
        logic       exp_ff;
        logic [2:0] exp_vld;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    task automatic set_full(input logic [2:0] f);
        bus.full_0 = f[0];
        bus.full_1 = f[1];
        bus.full_2 = f[2];
    endtask

    task automatic set_empty(input logic [2:0] e);
        bus.empty_0 = e[0];
        bus.empty_1 = e[1];
        bus.empty_2 = e[2];
    endtask

    task automatic set_rd(input logic [2:0] r);
        bus.read_enb_0 = r[0];
        bus.read_enb_1 = r[1];
        bus.read_enb_2 = r[2];
    endtask

    function automatic logic [2:0] vld_now();
        return {bus.vld_out_2, bus.vld_out_1, bus.vld_out_0};
    endfunction

    function automatic logic [2:0] sr_now();
        return {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};
    endfunction

    initial begin
        total  = 0;
        passed = 0;

        //            da    din    we    full    empty   exp_we  exp_ff exp_vld
        vecs[0]  = '{1'b1, 2'b01, 1'b1, 3'b111, 3'b111, 3'b000, 1'b0, 3'b000};
        vecs[1]  = '{1'b0, 2'b00, 1'b1, 3'b000, 3'b011, 3'b010, 1'b0, 3'b100};
        vecs[2]  = '{1'b0, 2'b00, 1'b1, 3'b010, 3'b000, 3'b010, 1'b1, 3'b111};
        vecs[3]  = '{1'b0, 2'b00, 1'b1, 3'b101, 3'b101, 3'b010, 1'b0, 3'b010};
        vecs[4]  = '{1'b0, 2'b00, 1'b1, 3'b010, 3'b111, 3'b010, 1'b1, 3'b000};
        vecs[5]  = '{1'b0, 2'b00, 1'b0, 3'b010, 3'b110, 3'b000, 1'b1, 3'b001};
        vecs[6]  = '{1'b1, 2'b11, 1'b1, 3'b111, 3'b111, 3'b010, 1'b1, 3'b000};
        vecs[7]  = '{1'b0, 2'b00, 1'b1, 3'b111, 3'b111, 3'b000, 1'b0, 3'b000};
        vecs[8]  = '{1'b1, 2'b00, 1'b0, 3'b001, 3'b111, 3'b000, 1'b0, 3'b000};
        vecs[9]  = '{1'b0, 2'b00, 1'b0, 3'b001, 3'b111, 3'b000, 1'b1, 3'b000};
        vecs[10] = '{1'b1, 2'b10, 1'b1, 3'b000, 3'b111, 3'b001, 1'b0, 3'b000};
        vecs[11] = '{1'b0, 2'b00, 1'b1, 3'b100, 3'b111, 3'b100, 1'b1, 3'b000};
        vecs[12] = '{1'b0, 2'b00, 1'b1, 3'b011, 3'b111, 3'b100, 1'b0, 3'b000};

        // Reset with requests and full flags asserted.
        resetn            = 1'b0;
        bus.detect_add    = 1'b0;
        bus.data_in       = 2'b00;
        bus.write_enb_reg = 1'b1;
        set_full(3'b111);
        set_empty(3'b010);
        set_rd(3'b111);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("rst_write_enb", 32'(bus.write_enb), 32'h0);
            check("rst_fifo_full", 32'(bus.fifo_full), 32'h0);
            check("rst_soft_reset", 32'(sr_now()), 32'h0);
            check("rst_vld_out", 32'(vld_now()), 32'h5);
        end
        @(negedge clk);
        resetn            = 1'b1;
        bus.write_enb_reg = 1'b0;
        set_empty(3'b111);

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            bus.detect_add    = vecs[i].da;
            bus.data_in       = vecs[i].din;
            bus.write_enb_reg = vecs[i].we;
            set_full(vecs[i].full);
            set_empty(vecs[i].empty);
            #1;
            check($sformatf("vec%0d_write_enb", i), 32'(bus.write_enb), 32'(vecs[i].exp_we));
            check($sformatf("vec%0d_fifo_full", i), 32'(bus.fifo_full), 32'(vecs[i].exp_ff));
            check($sformatf("vec%0d_vld_out", i), 32'(vld_now()), 32'(vecs[i].exp_vld));
        end

        // Quiesce before the watchdog sequences.
        @(negedge clk);
        bus.detect_add    = 1'b0;
        bus.write_enb_reg = 1'b0;
        set_full(3'b000);
        set_empty(3'b111);
        set_rd(3'b111);
        repeat (2) @(posedge clk);

        // Port 2 held stalled: pulses after edges 30 and 60 only.
        for (int k = 1; k <= 65; k++) begin
            @(negedge clk);
            set_empty(3'b011);
            set_rd(3'b011);
            @(posedge clk);
            #1;
            check($sformatf("p2_stall_k%0d", k), 32'(sr_now()),
                  (k == 30 || k == 60) ? 32'h4 : 32'h0);
        end
        @(negedge clk);
        set_empty(3'b111);
        set_rd(3'b111);
        repeat (2) @(posedge clk);

        // Port 0: 29 stalled, one read, 29 stalled -> never fires.
        for (int k = 1; k <= 59; k++) begin
            @(negedge clk);
            set_empty(3'b110);
            set_rd((k == 30) ? 3'b111 : 3'b110);
            @(posedge clk);
            #1;
            check($sformatf("p0_interrupt_k%0d", k), 32'(sr_now()), 32'h0);
        end
        @(negedge clk);
        set_empty(3'b111);
        set_rd(3'b111);
        repeat (2) @(posedge clk);

        // Port 1: 20 stalled, reset edge, then a full 30-cycle window before the pulse.
        for (int k = 1; k <= 56; k++) begin
            @(negedge clk);
            set_empty(3'b101);
            set_rd(3'b101);
            resetn = (k == 21) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("p1_reset_k%0d", k), 32'(sr_now()),
                  (k - 21 == 30) ? 32'h2 : 32'h0);
        end
        @(negedge clk);
        resetn = 1'b1;
        set_empty(3'b111);
        set_rd(3'b111);
        @(posedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
